// File: rtl/mul32_share_pkg.sv
// Shared types and widths for the time-shared 32x32 multiplier controller.
package mul32_share_pkg;

  localparam int DATA_W = 32;
  localparam int PROD_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/mul32_rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after
// the pointer, wrapping around. The pointer register lives in the parent.
module mul32_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant,
  output logic [$clog2(NUM_REQ)-1:0] grantIdx,
  output logic                       anyValid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  int               slot;
  logic [IDX_W-1:0] idx;

  always_comb begin
    grant    = '0;
    grantIdx = '0;
    anyValid = 1'b0;
    slot     = 0;
    idx      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      slot = int'(ptr) + k;
      if (slot >= NUM_REQ) begin
        slot = slot - NUM_REQ;
      end
      idx = IDX_W'(slot);
      if (!anyValid && req[idx]) begin
        anyValid    = 1'b1;
        grant[idx]  = 1'b1;
        grantIdx    = idx;
      end
    end
  end

endmodule

// File: rtl/mul32_share_ctrl.sv
// Time-shares one registered 32x32 multiplier between NUM_REQ requesters.
// Optional macro MUL32_SHARE_ZERO_BYPASS_EN: zero operands skip the multiplier.
module mul32_share_ctrl
  import mul32_share_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 1
) (
  input  logic                      iClk,
  input  logic                      iRst,
  input  logic [NUM_REQ-1:0]        iReqValid,
  output logic [NUM_REQ-1:0]        oReqReady,
  input  logic [NUM_REQ*DATA_W-1:0] iReqData0,
  input  logic [NUM_REQ*DATA_W-1:0] iReqData1,
  output logic [NUM_REQ-1:0]        oRspValid,
  input  logic [NUM_REQ-1:0]        iRspReady,
  output logic [PROD_W-1:0]         oRspData,
  output logic                      oMulEn,
  output logic                      oMulClr,
  output logic [DATA_W-1:0]         oMulData0,
  output logic [DATA_W-1:0]         oMulData1,
  input  logic [PROD_W-1:0]         iMulData
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MUL_LAT + 1);

  state_t             state;
  state_t             nextState;
  logic [IDX_W-1:0]   ptr;
  logic [IDX_W-1:0]   grantIdx;
  logic [IDX_W-1:0]   arbIdx;
  logic [NUM_REQ-1:0] arbGrant;
  logic               arbAny;
  logic [DATA_W-1:0]  opA;
  logic [DATA_W-1:0]  opB;
  logic [DATA_W-1:0]  selA;
  logic [DATA_W-1:0]  selB;
  logic [CNT_W-1:0]   cnt;
  logic [PROD_W-1:0]  rspData;
  logic               accept;
  logic               rspDone;
  logic               zeroOp;
  logic               lastWait;

  mul32_rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) uArbiter (
    .req     (iReqValid),
    .ptr     (ptr),
    .grant   (arbGrant),
    .grantIdx(arbIdx),
    .anyValid(arbAny)
  );

  assign selA     = iReqData0[int'(arbIdx)*DATA_W +: DATA_W];
  assign selB     = iReqData1[int'(arbIdx)*DATA_W +: DATA_W];
  assign accept   = (state == IDLE) && arbAny;
  assign rspDone  = (state == RESP) && iRspReady[grantIdx];
  assign lastWait = (state == WAIT) && (cnt == CNT_W'(1));
  assign oRspData = rspData;

`ifdef MUL32_SHARE_ZERO_BYPASS_EN
  // A zero operand makes the product trivially zero, so the multiplier is skipped.
  assign zeroOp = (selA == '0) || (selB == '0);
`else
  assign zeroOp = 1'b0;
`endif

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (arbAny) nextState = zeroOp ? RESP : ISSUE;
      ISSUE:   nextState = WAIT;
      WAIT:    if (cnt == CNT_W'(1)) nextState = RESP;
      RESP:    if (iRspReady[grantIdx]) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // The pointer only moves on response completion, so a persistent requester
  // cannot be served twice before every other persistent requester is served.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      ptr      <= '0;
      grantIdx <= '0;
      opA      <= '0;
      opB      <= '0;
      cnt      <= '0;
      rspData  <= '0;
    end else begin
      if (accept) begin
        grantIdx <= arbIdx;
        opA      <= selA;
        opB      <= selB;
        if (zeroOp) begin
          rspData <= '0;
        end
      end
      if (state == ISSUE) begin
        cnt <= CNT_W'(MUL_LAT);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
      if (lastWait) begin
        rspData <= iMulData;
      end
      if (rspDone) begin
        ptr <= (grantIdx == IDX_W'(NUM_REQ - 1)) ? '0 : grantIdx + IDX_W'(1);
      end
    end
  end

  always_comb begin
    oReqReady = '0;
    oRspValid = '0;
    oMulEn    = 1'b0;
    oMulClr   = 1'b1;
    oMulData0 = '0;
    oMulData1 = '0;
    case (state)
      IDLE: begin
        if (!iRst) oReqReady = arbGrant;
      end
      ISSUE: begin
        oMulEn    = 1'b1;
        oMulClr   = 1'b0;
        oMulData0 = opA;
        oMulData1 = opB;
      end
      WAIT: begin
        oMulClr = 1'b0;
      end
      RESP: begin
        oRspValid[grantIdx] = 1'b1;
      end
      default: begin
        oMulClr = 1'b1;
      end
    endcase
  end

endmodule
